// File: rtl/branch_predictor.sv
// Direct-mapped BTB with tag, target and saturating counter per entry.
// Build option: BP_BYPASS_EN forwards a same-cycle update to the lookup.
module branch_predictor #(
   parameter int DATA_W  = 64,
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int CNT_W   = 2
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              enable,
   input  logic              flush_bp,
   input  logic [DATA_W-1:0] lookup_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [DATA_W-1:0] pred_pc,
   input  logic              upd_valid,
   input  logic [DATA_W-1:0] upd_pc,
   input  logic              upd_is_jump,
   input  logic              upd_taken,
   input  logic [DATA_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   output logic              mispredict,
   output logic [31:0]       perf_updates,
   output logic [31:0]       perf_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};

   logic              valid_q [ENTRIES];
   logic [TAG_W-1:0]  tag_q   [ENTRIES];
   logic [DATA_W-1:0] tgt_q   [ENTRIES];
   logic [CNT_W-1:0]  cnt_q   [ENTRIES];

   logic              mis_q;
   logic [31:0]       perf_upd_q;
   logic [31:0]       perf_mis_q;

   logic [IDX_W-1:0]  uidx;
   logic [TAG_W-1:0]  utag;
   logic [IDX_W-1:0]  lidx;
   logic [TAG_W-1:0]  ltag;
   logic              u_hit;
   logic              mis_d;

   logic              wr_en;
   logic [DATA_W-1:0] wr_tgt;
   logic [CNT_W-1:0]  wr_cnt;

   logic              e_valid;
   logic [TAG_W-1:0]  e_tag;
   logic [DATA_W-1:0] e_tgt;
   logic [CNT_W-1:0]  e_cnt;

   logic              unused_pc_bits;

   assign uidx = upd_pc[IDX_W+1:2];
   assign utag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign lidx = lookup_pc[IDX_W+1:2];
   assign ltag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];

   assign unused_pc_bits = ^{upd_pc[DATA_W-1:IDX_W+TAG_W+2], upd_pc[1:0]};

   assign u_hit = valid_q[uidx] && (tag_q[uidx] == utag);

   // A jump the IF stage already predicted taken is never a mispredict.
   assign mis_d = upd_valid && (upd_taken != upd_pred_taken)
                  && !(upd_is_jump && upd_pred_taken);

   always_comb begin
      wr_en  = 1'b0;
      wr_tgt = tgt_q[uidx];
      wr_cnt = cnt_q[uidx];
      if (upd_valid) begin
         if (u_hit) begin
            wr_en = 1'b1;
            if (upd_is_jump) begin
               wr_cnt = CNT_MAX;
               wr_tgt = upd_target;
            end else if (upd_taken) begin
               wr_tgt = upd_target;
               if (cnt_q[uidx] != CNT_MAX)
                  wr_cnt = cnt_q[uidx] + 1'b1;
            end else if (cnt_q[uidx] != '0) begin
               wr_cnt = cnt_q[uidx] - 1'b1;
            end
         end else if (upd_taken || upd_is_jump) begin
            wr_en  = 1'b1;
            wr_tgt = upd_target;
            wr_cnt = upd_is_jump ? CNT_MAX : CNT_WT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            cnt_q[i]   <= CNT_WNT;
         end
         mis_q      <= 1'b0;
         perf_upd_q <= '0;
         perf_mis_q <= '0;
      end else if (enable) begin
         if (flush_bp) begin
            for (int i = 0; i < ENTRIES; i++)
               valid_q[i] <= 1'b0;
         end else if (wr_en) begin
            valid_q[uidx] <= 1'b1;
            tag_q[uidx]   <= utag;
            tgt_q[uidx]   <= wr_tgt;
            cnt_q[uidx]   <= wr_cnt;
         end
         mis_q <= mis_d;
         if (upd_valid && perf_upd_q != 32'hFFFF_FFFF)
            perf_upd_q <= perf_upd_q + 32'd1;
         if (mis_d && perf_mis_q != 32'hFFFF_FFFF)
            perf_mis_q <= perf_mis_q + 32'd1;
      end
   end

   always_comb begin
      e_valid = valid_q[lidx];
      e_tag   = tag_q[lidx];
      e_tgt   = tgt_q[lidx];
      e_cnt   = cnt_q[lidx];
`ifdef BP_BYPASS_EN
      if (enable && upd_valid && lidx == uidx && ltag == utag) begin
         if (flush_bp) begin
            e_valid = 1'b0;
         end else if (wr_en) begin
            e_valid = 1'b1;
            e_tag   = utag;
            e_tgt   = wr_tgt;
            e_cnt   = wr_cnt;
         end
      end
`endif
   end

   assign pred_hit   = e_valid && (e_tag == ltag);
   assign pred_taken = pred_hit && e_cnt[CNT_W-1];
   assign pred_pc    = pred_taken ? e_tgt : lookup_pc + DATA_W'(4);

   assign mispredict       = mis_q;
   assign perf_updates     = perf_upd_q;
   assign perf_mispredicts = perf_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
// Default parameters: 16 entries, 8-bit tag, 2-bit counters.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        srst;
   logic        enable;
   logic        flush_bp;
   logic [63:0] lookup_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [63:0] pred_pc;
   logic        upd_valid;
   logic [63:0] upd_pc;
   logic        upd_is_jump;
   logic        upd_taken;
   logic [63:0] upd_target;
   logic        upd_pred_taken;
   logic        mispredict;
   logic [31:0] perf_updates;
   logic [31:0] perf_mispredicts;

   int checks = 0;
   int errors = 0;

   branch_predictor dut (
      .clk              (clk),
      .srst             (srst),
      .enable           (enable),
      .flush_bp         (flush_bp),
      .lookup_pc        (lookup_pc),
      .pred_hit         (pred_hit),
      .pred_taken       (pred_taken),
      .pred_pc          (pred_pc),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_is_jump      (upd_is_jump),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_pred_taken   (upd_pred_taken),
      .mispredict       (mispredict),
      .perf_updates     (perf_updates),
      .perf_mispredicts (perf_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [63:0] pc, input logic jmp,
                      input logic tk, input logic [63:0] tgt,
                      input logic pt);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_is_jump    = jmp;
      upd_taken      = tk;
      upd_target     = tgt;
      upd_pred_taken = pt;
      tick();
      upd_valid = 1'b0;
   endtask

   task automatic look(input string tag, input logic [63:0] pc,
                       input logic hit, input logic tk,
                       input logic [63:0] npc);
      lookup_pc = pc;
      #1;
      chk({tag, "_hit"}, 64'(pred_hit), 64'(hit));
      chk({tag, "_tk"}, 64'(pred_taken), 64'(tk));
      chk({tag, "_pc"}, pred_pc, npc);
   endtask

   initial begin
      srst = 1'b1; enable = 1'b1; flush_bp = 1'b0;
      lookup_pc = 64'h100; upd_valid = 1'b0; upd_pc = '0;
      upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = '0;
      upd_pred_taken = 1'b0;
      tick();
      tick();
      srst = 1'b0;

      look("rst", 64'h100, 0, 0, 64'h104);
      chk("rst_mis", 64'(mispredict), 64'd0);
      chk("rst_pupd", 64'(perf_updates), 64'd0);
      chk("rst_pmis", 64'(perf_mispredicts), 64'd0);

      // allocate branch at 0x100, counter 2
      upd(64'h100, 0, 1, 64'h80, 0);
      chk("alloc_mis", 64'(mispredict), 64'd1);
      look("alloc", 64'h100, 1, 1, 64'h80);
      tick();
      chk("mis_clr", 64'(mispredict), 64'd0);

      upd(64'h100, 0, 0, 64'h0, 1);
      look("nt1", 64'h100, 1, 0, 64'h104);
      chk("nt1_mis", 64'(mispredict), 64'd1);
      upd(64'h100, 0, 0, 64'h0, 1);
      look("nt2", 64'h100, 1, 0, 64'h104);
      upd(64'h100, 0, 1, 64'h88, 1);
      look("t1", 64'h100, 1, 0, 64'h104);
      chk("t1_mis", 64'(mispredict), 64'd0);
      upd(64'h100, 0, 1, 64'h88, 1);
      look("t2", 64'h100, 1, 1, 64'h88);
      upd(64'h100, 0, 1, 64'h88, 1);
      upd(64'h100, 0, 1, 64'h88, 1);
      // saturated at 3: one not-taken keeps it taken
      upd(64'h100, 0, 0, 64'h0, 0);
      look("sat", 64'h100, 1, 1, 64'h88);
      upd(64'h100, 0, 0, 64'h0, 0);
      look("sat2", 64'h100, 1, 0, 64'h104);
      chk("p9_upd", 64'(perf_updates), 64'd9);
      chk("p9_mis", 64'(perf_mispredicts), 64'd3);

      // alias: 0x500 shares index 0 with a different tag
      upd(64'h500, 1, 1, 64'h1234, 0);
      look("alias_old", 64'h100, 0, 0, 64'h104);
      look("alias_new", 64'h500, 1, 1, 64'h1234);
      upd(64'h500, 1, 1, 64'h2000, 1);
      chk("jmp_nomis", 64'(mispredict), 64'd0);
      look("jmp_hit", 64'h500, 1, 1, 64'h2000);

      upd(64'h200, 0, 0, 64'h0, 0);
      look("nt_miss", 64'h200, 0, 0, 64'h204);
      chk("p12_upd", 64'(perf_updates), 64'd12);

      flush_bp = 1'b1;
      upd(64'h200, 0, 1, 64'h99, 0);
      flush_bp = 1'b0;
      look("fl_500", 64'h500, 0, 0, 64'h504);
      look("fl_200", 64'h200, 0, 0, 64'h204);
      chk("fl_pupd", 64'(perf_updates), 64'd13);
      chk("fl_pmis", 64'(perf_mispredicts), 64'd5);

      upd(64'h100, 0, 1, 64'h80, 0);
      look("realloc", 64'h100, 1, 1, 64'h80);

      // enable low: everything holds despite update and flush
      enable = 1'b0;
      flush_bp = 1'b1;
      upd_valid = 1'b1; upd_pc = 64'h100; upd_is_jump = 1'b0;
      upd_taken = 1'b0; upd_pred_taken = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      look("hold", 64'h100, 1, 1, 64'h80);
      chk("hold_mis", 64'(mispredict), 64'd1);
      chk("hold_pupd", 64'(perf_updates), 64'd14);
      chk("hold_pmis", 64'(perf_mispredicts), 64'd6);
      look("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0);
      upd_valid = 1'b0; flush_bp = 1'b0;
      enable = 1'b1;

      // same-cycle lookup of the updated entry
      lookup_pc = 64'h300;
      upd_valid = 1'b1; upd_pc = 64'h300; upd_is_jump = 1'b0;
      upd_taken = 1'b1; upd_target = 64'h40; upd_pred_taken = 1'b0;
      #1;
`ifdef BP_BYPASS_EN
      chk("byp_pc", pred_pc, 64'h40);
`else
      chk("byp_pc", pred_pc, 64'h304);
`endif
      tick();
      upd_valid = 1'b0;
      look("post_byp", 64'h300, 1, 1, 64'h40);
      chk("p15_upd", 64'(perf_updates), 64'd15);

      // reset wins over a coincident update
      srst = 1'b1;
      upd(64'h300, 1, 1, 64'h44, 0);
      srst = 1'b0;
      look("rst2", 64'h300, 0, 0, 64'h304);
      chk("rst2_mis", 64'(mispredict), 64'd0);
      chk("rst2_pupd", 64'(perf_updates), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the pipelined RISC-V core, the next step beyond the static not-taken policy with ID-stage resolution.
- Direct-mapped BTB with per-entry tag, target and saturating direction counter.
- Looked up combinationally by the IF-stage PC; trained by the ID stage when a branch or jump resolves.

Parameters:
- DATA_W, 64: PC and target width.
- ENTRIES, 16: BTB entries; power of two, 4..256. IDX_W = log2(ENTRIES).
- TAG_W, 8: tag bits stored per entry.
- CNT_W, 2: direction counter width; 2..4.

Ports:
- clk  input  1  clock.
- srst  input  1  reset.
- enable  input  1  global enable; low blocks all state updates.
- flush_bp  input  1  invalidate all entries.
- lookup_pc  input  DATA_W  IF-stage PC.
- pred_hit  output  1  valid entry with matching tag.
- pred_taken  output  1  hit and counter MSB = 1.
- pred_pc  output  DATA_W  stored target if pred_taken, else lookup_pc+4.
- upd_valid  input  1  ID stage resolved a control instruction this cycle.
- upd_pc  input  DATA_W  PC of the resolved instruction.
- upd_is_jump  input  1  unconditional jump.
- upd_taken  input  1  actual direction.
- upd_target  input  DATA_W  actual target.
- upd_pred_taken  input  1  prediction made for it in IF (pipelined copy of pred_taken).
- mispredict  output  1  registered; upd_valid & (upd_taken != upd_pred_taken) seen last cycle.
- perf_updates  output  32  resolved-update count.
- perf_mispredicts  output  32  misprediction count.

Interface (already decided): one clock, clk; reset srst is synchronous and active-high.

Behaviour:
- Indexing: index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] is ignored.
- Reset, on srst high at a clk edge:
  - all valid bits = 0;
  - counters = 2^(CNT_W-1)-1 (weakly not-taken);
  - mispredict = 0; perf counters = 0.
  - Outputs after reset: pred_hit = 0, pred_taken = 0, pred_pc = lookup_pc+4.
  - srst has priority over every other input.
- Lookup: purely combinational from registered state, zero latency. pred_pc+4 wraps modulo 2^DATA_W.
- Update: applied at the clk edge when enable & upd_valid, visible to lookup the following cycle.
  - Same-cycle lookup of the updated index returns the pre-update value (no bypass unless BP_BYPASS_EN).
  - Hit, conditional branch: counter +1 if taken, saturating at 2^CNT_W-1; -1 if not taken, saturating at 0. Target rewritten only when taken.
  - Hit, jump: counter = max; target = upd_target.
  - Miss and taken, or jump: allocate (overwrite whatever is at the index). valid = 1, tag written, target written. Counter = 2^(CNT_W-1) for a branch, max for a jump.
  - Miss and not taken: no allocation, no state change.
- flush_bp, with enable high: clears all valid bits at the edge; counters and targets are retained. If flush_bp and an update coincide, flush wins and the update is dropped. Perf counters are still updated.
- enable low: BTB, mispredict register and perf counters all hold. Lookup outputs remain live.
- mispredict: a 1-cycle registered pulse per offending update, cleared the cycle after. Jumps with upd_pred_taken = 1 are never mispredicts.
- Perf counters: +1 per accepted update and +1 per mispredict; each saturates at 0xFFFFFFFF (no wrap).

Optional Feature:
- Macro: BP_BYPASS_EN.
- Defined: if enable & upd_valid and lookup_pc index/tag equal upd_pc index/tag in the same cycle, the lookup outputs reflect the post-update entry (combinational forward).
  - A flush in the same cycle suppresses the bypass: output is a miss.
- Undefined: the lookup always reads registered state.
- perf_* behaviour is identical in both builds.

Test Plan (defaults):
- Reset, then lookup_pc = 0x100 -> pred_hit = 0, pred_taken = 0, pred_pc = 0x104; perf_updates = 0.
- Branch update upd_pc = 0x100, taken, target 0x80, upd_pred_taken = 0 -> next cycle mispredict = 1; lookup 0x100 gives hit, pred_taken = 1 (counter 2), pred_pc = 0x80. One cycle later mispredict = 0.
- Two not-taken updates at 0x100 after the allocation -> counter 2→1→0. Lookup gives pred_taken = 0, pred_pc = 0x104. Three further taken updates -> counter saturates at 3.
- Alias: allocate 0x100, then jump at 0x500 (same index 0, different tag) -> lookup 0x100 misses; lookup 0x500 gives pred_pc = upd_target.
- flush_bp together with an update at 0x200 -> all lookups miss next cycle; perf_updates still increments. With enable = 0, all state holds across 5 cycles.
- BP_BYPASS_EN defined: update 0x300 taken to 0x40 while lookup_pc = 0x300 in the same cycle -> pred_pc = 0x40 that cycle. Undefined: pred_pc = 0x304.
